mfda_stage_sequencer: RTL and testbench

Clocked controller that sequences fluid through a parametrised linear chain of N processing stages: source inlet, then per stage a chamber (mix), heater or filter, then outlet. It replaces fixed hand-wired stage chains with one block that opens each stage's inlet valve, runs that stage's actuator for a programmable dwell, and advances to the next stage. It sits between the host control interface and the valve, heater and mixer drivers of the chip.

---
 rtl/mfda_stage_sequencer.sv | 175 +++++++++++++++++
 tb/tb_mfda_stage_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfda_stage_sequencer.sv
// mfda_stage_sequencer: moves fluid through a linear chain of N_STAGES processing stages.
// A run fills each stage through its inlet valve and then runs the stage's actuator
// (mixer, heater, passive filter hold, or nothing for bypass) for a latched dwell.
// After the last stage the outlet valve drains the chain.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, abort           run control (start is level-sampled in IDLE; abort wins)
//   stage_mode, dwell      per-stage configuration, latched when a run starts
//   valve_en               inlet valves [N_STAGES-1:0], outlet valve [N_STAGES]
//   mix_en, heater_en      per-stage actuator drives
//   busy, active_stage     run status
//   done, aborted          one-cycle completion / abort pulses
module mfda_stage_sequencer #(
  parameter int unsigned N_STAGES    = 4,
  parameter int unsigned DWELL_W     = 16,
  parameter int unsigned FILL_CYCLES = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [2*N_STAGES-1:0]         stage_mode,
  input  logic [N_STAGES*DWELL_W-1:0]   dwell,
  output logic [N_STAGES:0]             valve_en,
  output logic [N_STAGES-1:0]           mix_en,
  output logic [N_STAGES-1:0]           heater_en,
  output logic                          busy,
  output logic [3:0]                    active_stage,
  output logic                          done,
  output logic                          aborted
);

  localparam int unsigned FILL_W = $clog2(FILL_CYCLES + 1);
  localparam int unsigned CNT_W  = (DWELL_W > FILL_W) ? DWELL_W : FILL_W;
  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       LAST_STAGE = 4'(N_STAGES - 1);
  localparam logic [1:0]       MODE_MIX    = 2'b00;
  localparam logic [1:0]       MODE_HEAT   = 2'b01;
  localparam logic [1:0]       MODE_BYPASS = 2'b11;

  typedef enum logic [2:0] {StIdle, StFill, StProcess, StDrain, StDone} state_e;

  state_e                      state_q, state_d;
  logic [3:0]                  stage_q, stage_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [2*N_STAGES-1:0]       mode_q;
  logic [N_STAGES*DWELL_W-1:0] dwell_q;
  logic                        load;
  logic                        advance;

  logic [1:0]         cur_mode;
  logic [DWELL_W-1:0] cur_dwell;
  logic [DWELL_W-1:0] eff_dwell;

  logic [N_STAGES:0]   valve_d;
  logic [N_STAGES-1:0] mix_d;
  logic [N_STAGES-1:0] heat_d;

  // Configuration of the stage currently being sequenced.
  always_comb begin
    cur_mode  = 2'b00;
    cur_dwell = '0;
    for (int i = 0; i < int'(N_STAGES); i++) begin
      if (stage_q == 4'(i)) begin
        cur_mode  = mode_q[2*i +: 2];
        cur_dwell = dwell_q[i*DWELL_W +: DWELL_W];
      end
    end
    eff_dwell = (cur_mode == MODE_BYPASS) ? '0 : cur_dwell;
  end

  // Counters are preloaded with length-1 so each phase lasts exactly its length.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          load    = 1'b1;
          state_d = StFill;
          stage_d = '0;
          cnt_d   = FILL_LAST;
        end
      end
      StFill: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (eff_dwell != '0) begin
          state_d = StProcess;
          cnt_d   = CNT_W'(eff_dwell) - CNT_ONE;
        end else begin
          advance = 1'b1;
        end
      end
      StProcess: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
        else             advance = 1'b1;
      end
      StDrain: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
        else             state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (advance) begin
      cnt_d = FILL_LAST;
      if (stage_q == LAST_STAGE) begin
        state_d = StDrain;
      end else begin
        state_d = StFill;
        stage_d = stage_q + 4'd1;
      end
    end

    if (abort && state_q != StIdle) state_d = StIdle;

    if (state_d == StIdle) begin
      stage_d = '0;
      cnt_d   = '0;
    end
  end

  // Outputs are decoded from the next state so they line up with it once registered.
  // PROCESS is only entered from FILL of the same stage, so cur_mode is the right mode.
  always_comb begin
    valve_d = '0;
    mix_d   = '0;
    heat_d  = '0;
    for (int i = 0; i < int'(N_STAGES); i++) begin
      valve_d[i] = (state_d == StFill) && (stage_d == 4'(i));
      mix_d[i]   = (state_d == StProcess) && (stage_d == 4'(i)) && (cur_mode == MODE_MIX);
      heat_d[i]  = (state_d == StProcess) && (stage_d == 4'(i)) && (cur_mode == MODE_HEAT);
    end
    valve_d[N_STAGES] = (state_d == StDrain);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      stage_q      <= '0;
      cnt_q        <= '0;
      mode_q       <= '0;
      dwell_q      <= '0;
      valve_en     <= '0;
      mix_en       <= '0;
      heater_en    <= '0;
      busy         <= 1'b0;
      active_stage <= '0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      cnt_q        <= cnt_d;
      if (load) begin
        mode_q  <= stage_mode;
        dwell_q <= dwell;
      end
      valve_en     <= valve_d;
      mix_en       <= mix_d;
      heater_en    <= heat_d;
      busy         <= (state_d != StIdle);
      active_stage <= stage_d;
      done         <= (state_d == StDone);
      aborted      <= abort && (state_q != StIdle);
    end
  end

endmodule

// File: tb/tb_mfda_stage_sequencer.sv
// tb_mfda_stage_sequencer: directed bench for mfda_stage_sequencer.
// u0 is the default 4-stage chain; u1 is a 1-stage, 4-bit-dwell chain for the maximum dwell case.
// Cycle c means the clock period after edge c, where edge 0 samples start.
module tb_mfda_stage_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance.
  logic        start0 = 1'b0;
  logic        abort0 = 1'b0;
  logic [7:0]  mode0 = '0;
  logic [63:0] dwell0 = '0;
  logic [4:0]  valve0;
  logic [3:0]  mix0;
  logic [3:0]  heat0;
  logic        busy0;
  logic [3:0]  stage0;
  logic        done0;
  logic        abrt0;
  logic [19:0] out0;
  assign out0 = {valve0, mix0, heat0, busy0, stage0, done0, abrt0};

  // Single-stage instance.
  logic        start1 = 1'b0;
  logic        abort1 = 1'b0;
  logic [1:0]  mode1 = '0;
  logic [3:0]  dwell1 = '0;
  logic [1:0]  valve1;
  logic [0:0]  mix1;
  logic [0:0]  heat1;
  logic        busy1;
  logic [3:0]  stage1;
  logic        done1;
  logic        abrt1;

  int total = 0;
  int bad = 0;

  mfda_stage_sequencer #(.N_STAGES(4), .DWELL_W(16), .FILL_CYCLES(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .stage_mode(mode0), .dwell(dwell0), .valve_en(valve0), .mix_en(mix0),
    .heater_en(heat0), .busy(busy0), .active_stage(stage0), .done(done0), .aborted(abrt0)
  );

  mfda_stage_sequencer #(.N_STAGES(1), .DWELL_W(4), .FILL_CYCLES(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .stage_mode(mode1), .dwell(dwell1), .valve_en(valve1), .mix_en(mix1),
    .heater_en(heat1), .busy(busy1), .active_stage(stage1), .done(done1), .aborted(abrt1)
  );

  // Mixed-mode config: stage0 mix/10, stage1 filter/5, stage2 heat/20, stage3 bypass/7.
  localparam logic [7:0]  MIXED_MODE  = 8'b11_01_10_00;
  localparam logic [63:0] MIXED_DWELL = {16'd7, 16'd20, 16'd5, 16'd10};

  task automatic begin_run0(input logic [7:0] m, input logic [63:0] d, input logic hold);
    @(negedge clk);
    mode0  = m;
    dwell0 = d;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start0 = 1'b0;
    // Scramble inputs to show they were latched.
    mode0  = 8'h5A;
    dwell0 = 64'h0003_0001_0002_0004;
  endtask

  task automatic test_reset;
    #12;
    total++;
    if (out0 !== 20'h0) begin
      bad++;
      $display("FAIL reset_u0 got=%h want=%h", out0, 20'h0);
    end
    total++;
    if ({valve1, mix1, heat1, busy1, stage1, done1, abrt1} !== 11'h0) begin
      bad++;
      $display("FAIL reset_u1 got=%h want=0", {valve1, mix1, heat1, busy1, stage1, done1, abrt1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mixed;
    logic [4:0] ev;
    logic [3:0] em, eh;
    begin_run0(MIXED_MODE, MIXED_DWELL, 1'b0);
    for (int c = 1; c <= 77; c++) begin
      @(negedge clk);
      ev = 5'd0;
      if (c >= 1 && c <= 8)   ev = 5'b00001;
      if (c >= 19 && c <= 26) ev = 5'b00010;
      if (c >= 32 && c <= 39) ev = 5'b00100;
      if (c >= 60 && c <= 67) ev = 5'b01000;
      if (c >= 68 && c <= 75) ev = 5'b10000;
      em = (c >= 9 && c <= 18) ? 4'b0001 : 4'b0000;
      eh = (c >= 40 && c <= 59) ? 4'b0100 : 4'b0000;
      total++;
      if ({valve0, mix0, heat0} !== {ev, em, eh}) begin
        bad++;
        $display("FAIL mixed_drive c=%0d got=%h want=%h", c, {valve0, mix0, heat0}, {ev, em, eh});
      end
      total++;
      if ({busy0, done0, abrt0} !== {(c <= 76), (c == 76), 1'b0}) begin
        bad++;
        $display("FAIL mixed_status c=%0d got=%b want=%b", c, {busy0, done0, abrt0},
                 {(c <= 76), (c == 76), 1'b0});
      end
      if (c <= 67 || c == 77) begin
        total++;
        if (stage0 !== ((c == 77) ? 4'd0 : (c <= 18) ? 4'd0 : (c <= 31) ? 4'd1 :
                        (c <= 59) ? 4'd2 : 4'd3)) begin
          bad++;
          $display("FAIL mixed_stage c=%0d got=%0d", c, stage0);
        end
      end
    end
  endtask

  task automatic test_bypass;
    logic [4:0] ev;
    begin_run0(8'hFF, {4{16'd9}}, 1'b0);
    for (int c = 1; c <= 42; c++) begin
      @(negedge clk);
      ev = 5'd0;
      if (c >= 1 && c <= 8)   ev = 5'b00001;
      if (c >= 9 && c <= 16)  ev = 5'b00010;
      if (c >= 17 && c <= 24) ev = 5'b00100;
      if (c >= 25 && c <= 32) ev = 5'b01000;
      if (c >= 33 && c <= 40) ev = 5'b10000;
      total++;
      if ({valve0, mix0, heat0, busy0, done0} !== {ev, 8'h00, (c <= 41), (c == 41)}) begin
        bad++;
        $display("FAIL bypass c=%0d got=%h want=%h", c, {valve0, mix0, heat0, busy0, done0},
                 {ev, 8'h00, (c <= 41), (c == 41)});
      end
    end
  endtask

  task automatic test_abort;
    begin_run0(MIXED_MODE, MIXED_DWELL, 1'b0);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 15) begin
        total++;
        if (mix0 !== 4'b0001) begin
          bad++;
          $display("FAIL abort_pre got=%b want=0001", mix0);
        end
        abort0 = 1'b1;
      end
      if (c == 16) begin
        abort0 = 1'b0;
        total++;
        if (out0 !== 20'h00001) begin
          bad++;
          $display("FAIL abort_cycle got=%h want=%h", out0, 20'h00001);
        end
      end
      if (c >= 17) begin
        total++;
        if (out0 !== 20'h0) begin
          bad++;
          $display("FAIL abort_after c=%0d got=%h want=0", c, out0);
        end
      end
    end
  endtask

  task automatic test_start_abort_idle;
    @(negedge clk);
    mode0  = MIXED_MODE;
    dwell0 = MIXED_DWELL;
    start0 = 1'b1;
    abort0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    abort0 = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      total++;
      if (out0 !== 20'h0) begin
        bad++;
        $display("FAIL start_abort_idle c=%0d got=%h want=0", c, out0);
      end
    end
  endtask

  task automatic test_back_to_back;
    begin_run0(MIXED_MODE, MIXED_DWELL, 1'b1);
    for (int c = 1; c <= 78; c++) begin
      @(negedge clk);
      total++;
      if ({busy0, done0} !== {(c <= 76 || c == 78), (c == 76)}) begin
        bad++;
        $display("FAIL b2b_status c=%0d got=%b want=%b", c, {busy0, done0},
                 {(c <= 76 || c == 78), (c == 76)});
      end
      if (c == 77 || c == 78) begin
        total++;
        if (valve0 !== ((c == 78) ? 5'b00001 : 5'b00000)) begin
          bad++;
          $display("FAIL b2b_valve c=%0d got=%b", c, valve0);
        end
      end
    end
    start0 = 1'b0;
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midrun;
    begin_run0(MIXED_MODE, MIXED_DWELL, 1'b0);
    for (int c = 1; c <= 12; c++) @(negedge clk);
    total++;
    if (mix0 !== 4'b0001) begin
      bad++;
      $display("FAIL rst_pre got=%b want=0001", mix0);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (out0 !== 20'h0) begin
      bad++;
      $display("FAIL rst_async got=%h want=0", out0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    begin_run0(MIXED_MODE, MIXED_DWELL, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      total++;
      if ({valve0, mix0, busy0, stage0} !== {((c <= 8) ? 5'b00001 : 5'b00000),
                                              ((c == 9) ? 4'b0001 : 4'b0000), 1'b1, 4'd0}) begin
        bad++;
        $display("FAIL rst_rerun c=%0d got=%h", c, {valve0, mix0, busy0, stage0});
      end
    end
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_max_dwell;
    int hcount;
    hcount = 0;
    @(negedge clk);
    mode1  = 2'b01;
    dwell1 = 4'd15;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    dwell1 = 4'd2;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (heat1[0]) hcount++;
      total++;
      if ({valve1, heat1, done1, busy1} !== {((c <= 8) ? 2'b01 : (c >= 24 && c <= 31) ? 2'b10 : 2'b00),
                                             (c >= 9 && c <= 23), (c == 32), (c <= 32)}) begin
        bad++;
        $display("FAIL maxdwell c=%0d got=%b", c, {valve1, heat1, done1, busy1});
      end
    end
    total++;
    if (hcount != 15) begin
      bad++;
      $display("FAIL maxdwell_count got=%0d want=15", hcount);
    end
  endtask

  initial begin
    test_reset;
    test_mixed;
    test_bypass;
    test_abort;
    test_start_abort_idle;
    test_back_to_back;
    test_reset_midrun;
    test_max_dwell;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
